// File: rtl/door_alarm_pkg.sv
// Shared definitions for the door alarm buzzer sequencer: state encoding,
// default timing constants and a small sizing helper.
package door_alarm_pkg;

  typedef enum logic [2:0] {
    StIdle       = 3'd0,
    StBeepOn     = 3'd1,
    StBeepOff    = 3'd2,
    StContinuous = 3'd3,
    StSnooze     = 3'd4
  } state_e;

  localparam int unsigned DefBeepOnCycles        = 4;
  localparam int unsigned DefBeepOffCycles       = 4;
  localparam int unsigned DefBeepsBeforeEscalate = 3;
  localparam int unsigned DefSnoozeCycles        = 20;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/door_alarm_sequencer_cycle_timer.sv
// Loadable saturating down-counter; done is high once the loaded count has
// fully elapsed. One instance times every phase of the alarm pattern.
module cycle_timer #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic             done
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= load_value;
    end else if (r_count != '0) begin
      r_count <= r_count - WIDTH'(1);
    end
  end

  assign done = (r_count == '0);

endmodule

// File: rtl/door_alarm_sequencer.sv
// Turns the door-open warning level into a beep pattern that escalates to a
// continuous tone, with a timed snooze on a user mute pulse.
module door_alarm_sequencer
  import door_alarm_pkg::*;
#(
  parameter int unsigned BEEP_ON_CYCLES        = DefBeepOnCycles,
  parameter int unsigned BEEP_OFF_CYCLES       = DefBeepOffCycles,
  parameter int unsigned BEEPS_BEFORE_ESCALATE = DefBeepsBeforeEscalate,
  parameter int unsigned SNOOZE_CYCLES         = DefSnoozeCycles
) (
  input  logic clock,
  input  logic reset,
  input  logic warn_door_open,
  input  logic mute,
  output logic buzzer,
  output logic escalated,
  output logic snoozed
);

  localparam int unsigned TimerMax = max3(BEEP_ON_CYCLES, BEEP_OFF_CYCLES, SNOOZE_CYCLES);
  localparam int unsigned TW       = $clog2(TimerMax + 1);
  localparam int unsigned BW       = $clog2(BEEPS_BEFORE_ESCALATE + 1);

  state_e        r_state;
  state_e        w_state_d;
  logic [BW-1:0] r_beep_cnt;
  logic [BW-1:0] w_beep_d;
  logic [BW-1:0] w_beep_next;
  logic          w_timer_done;
  logic          w_timer_load;
  logic [TW-1:0] w_load_value;
  logic          r_buzzer;
  logic          r_escalated;
  logic          r_snoozed;

  assign w_beep_next = (r_beep_cnt == BW'(BEEPS_BEFORE_ESCALATE)) ? r_beep_cnt
                                                                   : r_beep_cnt + BW'(1);

  always_comb begin
    w_state_d = r_state;
    w_beep_d  = r_beep_cnt;
    case (r_state)
      StIdle: begin
        if (warn_door_open) begin
          w_state_d = StBeepOn;
          w_beep_d  = '0;
        end
      end
      StBeepOn: begin
        if (!warn_door_open) begin
          w_state_d = StIdle;
        end else if (mute) begin
          w_state_d = StSnooze;
        end else if (w_timer_done) begin
          w_beep_d  = w_beep_next;
          w_state_d = (w_beep_next == BW'(BEEPS_BEFORE_ESCALATE)) ? StContinuous : StBeepOff;
        end
      end
      StBeepOff: begin
        if (!warn_door_open) begin
          w_state_d = StIdle;
        end else if (mute) begin
          w_state_d = StSnooze;
        end else if (w_timer_done) begin
          w_state_d = StBeepOn;
        end
      end
      StContinuous: begin
        if (!warn_door_open) begin
          w_state_d = StIdle;
        end else if (mute) begin
          w_state_d = StSnooze;
        end
      end
      StSnooze: begin
        if (!warn_door_open) begin
          w_state_d = StIdle;
        end else if (w_timer_done) begin
          w_state_d = StBeepOn;
          w_beep_d  = '0;
        end
      end
      default: begin
        w_state_d = StIdle;
        w_beep_d  = '0;
      end
    endcase
  end

  // Loading N-1 on entry makes done rise on the Nth cycle spent in the state.
  always_comb begin
    w_timer_load = (w_state_d != r_state);
    w_load_value = '0;
    case (w_state_d)
      StBeepOn:  w_load_value = TW'(BEEP_ON_CYCLES - 1);
      StBeepOff: w_load_value = TW'(BEEP_OFF_CYCLES - 1);
      StSnooze:  w_load_value = TW'(SNOOZE_CYCLES - 1);
      default:   w_load_value = '0;
    endcase
  end

  cycle_timer #(
    .WIDTH(TW)
  ) u_timer (
    .clock      (clock),
    .reset      (reset),
    .load       (w_timer_load),
    .load_value (w_load_value),
    .done       (w_timer_done)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= StIdle;
      r_beep_cnt  <= '0;
      r_buzzer    <= 1'b0;
      r_escalated <= 1'b0;
      r_snoozed   <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_beep_cnt  <= w_beep_d;
      r_buzzer    <= (w_state_d == StBeepOn) || (w_state_d == StContinuous);
      r_escalated <= (w_state_d == StContinuous);
      r_snoozed   <= (w_state_d == StSnooze);
    end
  end

  assign buzzer    = r_buzzer;
  assign escalated = r_escalated;
  assign snoozed   = r_snoozed;

endmodule

// File: tb/tb_door_alarm_sequencer.sv
// Self-checking bench: directed scenarios plus random warn/mute/reset traffic,
// compared against a time-since-pattern-start reference model.
module tb_door_alarm_sequencer;
  import door_alarm_pkg::*;

  localparam int OnC    = DefBeepOnCycles;
  localparam int OffC   = DefBeepOffCycles;
  localparam int NBeeps = DefBeepsBeforeEscalate;
  localparam int SnzC   = DefSnoozeCycles;
  localparam int Period = OnC + OffC;
  localparam int EscT   = (NBeeps - 1) * Period + OnC;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic warn  = 1'b0;
  logic mute  = 1'b0;
  logic buzzer, escalated, snoozed;

  int checks   = 0;
  int failures = 0;

  // Model: either idle, sounding with m_t cycles since the pattern began,
  // or snoozing with m_st cycles of snooze elapsed.
  bit m_active = 1'b0;
  bit m_snooze = 1'b0;
  int m_t      = 0;
  int m_st     = 0;

  door_alarm_sequencer #(
    .BEEP_ON_CYCLES        (OnC),
    .BEEP_OFF_CYCLES       (OffC),
    .BEEPS_BEFORE_ESCALATE (NBeeps),
    .SNOOZE_CYCLES         (SnzC)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .warn_door_open (warn),
    .mute           (mute),
    .buzzer         (buzzer),
    .escalated      (escalated),
    .snoozed        (snoozed)
  );

  always #5 clock = ~clock;

  function automatic logic [2:0] model_out();
    logic cont;
    if (m_snooze) return 3'b001;
    if (!m_active) return 3'b000;
    cont = (m_t >= EscT);
    return {cont || ((m_t % Period) < OnC), cont, 1'b0};
  endfunction

  task automatic step(input logic r, input logic w, input logic m);
    @(negedge clock);
    reset = r;
    warn  = w;
    mute  = m;
    @(posedge clock);
    if (r || !w) begin
      m_active = 1'b0;
      m_snooze = 1'b0;
    end else if (m_snooze) begin
      m_st++;
      if (m_st >= SnzC) begin
        m_snooze = 1'b0;
        m_active = 1'b1;
        m_t      = 0;
      end
    end else if (m_active) begin
      if (m) begin
        m_active = 1'b0;
        m_snooze = 1'b1;
        m_st     = 0;
      end else if (m_t < EscT) begin
        m_t++;
      end
    end else begin
      m_active = 1'b1;
      m_t      = 0;
    end
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 15; i++) begin
      step(1'b1, 1'b1, 1'b0);
      checks++;
      if ({buzzer, escalated, snoozed} !== 3'b000) begin
        failures++;
        $display("FAIL reset cyc=%0d got=%b exp=000", i, {buzzer, escalated, snoozed});
      end
    end
  endtask

  task automatic test_pattern();
    for (int i = 0; i < 32; i++) begin
      step(1'b0, 1'b1, 1'b0);
      checks++;
      if ({buzzer, escalated, snoozed} !== model_out()) begin
        failures++;
        $display("FAIL pattern cyc=%0d got=%b exp=%b", i, {buzzer, escalated, snoozed},
                 model_out());
      end
    end
    // Cycle 31 is well past escalation: must be a steady tone.
    checks++;
    if ({buzzer, escalated} !== 2'b11) begin
      failures++;
      $display("FAIL escalate got=%b exp=11", {buzzer, escalated});
    end
    step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_warn_drop();
    for (int i = 0; i < 40; i++) begin
      step(1'b0, !(i >= 6 && i < 11), 1'b0);
      checks++;
      if ({buzzer, escalated, snoozed} !== model_out()) begin
        failures++;
        $display("FAIL warn_drop cyc=%0d got=%b exp=%b", i, {buzzer, escalated, snoozed},
                 model_out());
      end
    end
    step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_mute_snooze();
    for (int i = 0; i < 60; i++) begin
      step(1'b0, 1'b1, (i == 25) || (i == 30));
      checks++;
      if ({buzzer, escalated, snoozed} !== model_out()) begin
        failures++;
        $display("FAIL mute_snooze cyc=%0d got=%b exp=%b", i, {buzzer, escalated, snoozed},
                 model_out());
      end
    end
    step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_priority();
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, 1'b1);
      checks++;
      if ({buzzer, escalated, snoozed} !== 3'b000) begin
        failures++;
        $display("FAIL priority cyc=%0d got=%b exp=000", i, {buzzer, escalated, snoozed});
      end
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 25; i++) step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    checks++;
    if ({buzzer, escalated, snoozed} !== 3'b000) begin
      failures++;
      $display("FAIL reset_mid got=%b exp=000", {buzzer, escalated, snoozed});
    end
    step(1'b0, 1'b1, 1'b0);
    checks++;
    if ({buzzer, escalated, snoozed} !== 3'b100) begin
      failures++;
      $display("FAIL reset_release got=%b exp=100", {buzzer, escalated, snoozed});
    end
    step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    logic r, w, m;
    for (int i = 0; i < 3000; i++) begin
      r = ($urandom_range(0, 199) == 0);
      w = ($urandom_range(0, 24) != 0);
      m = ($urandom_range(0, 39) == 0);
      step(r, w, m);
      checks++;
      if ({buzzer, escalated, snoozed} !== model_out()) begin
        failures++;
        $display("FAIL random cyc=%0d r=%b w=%b m=%b got=%b exp=%b", i, r, w, m,
                 {buzzer, escalated, snoozed}, model_out());
      end
    end
  endtask

  initial begin
    test_reset();
    test_pattern();
    test_warn_drop();
    test_mute_snooze();
    test_priority();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
